// File: rtl/spio_uart_rx_pkg.sv
// Shared UART definitions: serial line levels and receiver state encodings.
// Testbenches import this package to decode the receiver state.
package spio_uart_rx_pkg;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StData     = 3'd2,
        StStop     = 3'd3,
        StWaitIdle = 3'd4
    } rx_state_e;

endpackage

// File: rtl/spio_uart_sync.sv
// Multi-flop synchroniser for an asynchronous UART line (RX, CTS, RTS).
// Ports:
//   clk   - sampling clock
//   reset - synchronous active-high reset; every stage resets to LINE_IDLE
//   d     - asynchronous input
//   q     - synchronised output (final stage)
module spio_uart_sync
    import spio_uart_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk) begin
        if (reset) begin
            stages <= {SYNC_STAGES{LINE_IDLE}};
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/spio_uart_rx.sv
// 8N1 UART receiver. Oversamples the synchronised RX line using the shared
// baud generator pulse, validates the start bit at mid-bit, samples data
// bits LSB first and checks the stop bit.
// Ports:
//   CLK_IN          - common clock
//   RESET_IN        - synchronous active-high reset
//   SAMPLE_PULSE_IN - one-cycle pulse, OVERSAMPLE per bit period
//   RX_IN           - asynchronous serial line
//   DATA_OUT        - received byte, stable while VLD_OUT and not consumed
//   VLD_OUT         - DATA_OUT holds an unconsumed byte
//   RDY_IN          - consumer ready; transfer when VLD_OUT && RDY_IN
//   FRAME_ERR_OUT   - one-cycle pulse on a bad stop bit
//   OVERRUN_OUT     - one-cycle pulse when a completed byte is dropped
module spio_uart_rx
    import spio_uart_rx_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       CLK_IN,
    input  logic       RESET_IN,
    input  logic       SAMPLE_PULSE_IN,
    input  logic       RX_IN,
    output logic [7:0] DATA_OUT,
    output logic       VLD_OUT,
    input  logic       RDY_IN,
    output logic       FRAME_ERR_OUT,
    output logic       OVERRUN_OUT
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

    rx_state_e       state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            byte_done;
    logic            line;

    spio_uart_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (CLK_IN),
        .reset(RESET_IN),
        .d    (RX_IN),
        .q    (line)
    );

    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            state         <= StIdle;
            cnt           <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            byte_done     <= 1'b0;
            DATA_OUT      <= 8'h00;
            VLD_OUT       <= 1'b0;
            FRAME_ERR_OUT <= 1'b0;
            OVERRUN_OUT   <= 1'b0;
        end else begin
            byte_done     <= 1'b0;
            FRAME_ERR_OUT <= 1'b0;
            OVERRUN_OUT   <= 1'b0;

            // Delivery one edge after the good stop sample. A byte arriving
            // while the previous one is still held (and not being taken
            // this cycle) is dropped.
            if (byte_done) begin
                if (!VLD_OUT || RDY_IN) begin
                    DATA_OUT <= shift;
                    VLD_OUT  <= 1'b1;
                end else begin
                    OVERRUN_OUT <= 1'b1;
                end
            end else if (VLD_OUT && RDY_IN) begin
                VLD_OUT <= 1'b0;
            end

            case (state)
                StIdle: begin
                    if (SAMPLE_PULSE_IN && line == START_BIT) begin
                        state <= StStart;
                        cnt   <= '0;
                    end
                end
                StStart: begin
                    if (SAMPLE_PULSE_IN) begin
                        if (cnt == HALF_LAST) begin
                            // Line back high at mid start bit: a glitch.
                            if (line == LINE_IDLE) begin
                                state <= StIdle;
                            end else begin
                                state   <= StData;
                                cnt     <= '0;
                                bit_idx <= '0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                StData: begin
                    if (SAMPLE_PULSE_IN) begin
                        if (cnt == FULL_LAST) begin
                            shift   <= {line, shift[7:1]};
                            cnt     <= '0;
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == 3'd7) begin
                                state <= StStop;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                StStop: begin
                    if (SAMPLE_PULSE_IN) begin
                        if (cnt == FULL_LAST) begin
                            cnt <= '0;
                            if (line == STOP_BIT) begin
                                byte_done <= 1'b1;
                                state     <= StIdle;
                            end else begin
                                FRAME_ERR_OUT <= 1'b1;
                                state         <= StWaitIdle;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                StWaitIdle: begin
                    // Hold off until the line recovers so a break or a
                    // stuck-low line reports only one framing error.
                    if (SAMPLE_PULSE_IN && line == LINE_IDLE) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/spio_uart_rx.md
Name: spio_uart_rx

Overview:
- UART receiver; the receive-side counterpart of spio_uart_tx on the same 8N1 serial line (1 start bit, 8 data bits LSB first, 1 stop bit).
- Synchronises the asynchronous RX line, detects and validates start bits using an oversampling pulse from the shared baud generator, and samples each bit at mid-bit.
- Delivers each byte on a rdy/vld interface; flags framing errors and overruns.
- Sits between the board-level RX pin and the UART command/packet logic.

Parameters:
- OVERSAMPLE, 16, sample pulses per bit period; must be an even value >= 4.
- SYNC_STAGES, 2, number of flip-flops in the RX input synchroniser; >= 2.

Ports:
- CLK_IN  input  1  common clock.
- RESET_IN  input  1  reset, synchronous, active-high.
- SAMPLE_PULSE_IN  input  1  single-cycle pulse from the baud generator, OVERSAMPLE times per bit period.
- RX_IN  input  1  asynchronous serial line.
- DATA_OUT  output  8  received byte.
- VLD_OUT  output  1  DATA_OUT holds an unconsumed byte.
- RDY_IN  input  1  consumer accepts DATA_OUT; transfer occurs when VLD_OUT && RDY_IN at a clock edge.
- FRAME_ERR_OUT  output  1  one-cycle pulse: a stop bit was sampled as not STOP_BIT.
- OVERRUN_OUT  output  1  one-cycle pulse: a completed byte was dropped.

Behaviour:
- Reset (synchronous; applies to the whole block, including mid-frame):
  - next state IDLE; all synchroniser flops = LINE_IDLE; counters = 0.
  - VLD_OUT=0, FRAME_ERR_OUT=0, OVERRUN_OUT=0, DATA_OUT=8'h00.
  - A partial frame in progress is discarded.
- "line" means the final synchroniser stage. Sample counter width is clog2(OVERSAMPLE). All counting advances only on cycles where SAMPLE_PULSE_IN=1.
- State machine:
  - IDLE: on a pulse with line==START_BIT -> START, counter=0.
  - START: on the pulse where counter==OVERSAMPLE/2-1, sample the line (mid start bit).
    - line==LINE_IDLE -> false start (glitch), return to IDLE.
    - otherwise -> DATA, counter=0, bit index=0.
  - DATA: on the pulse where counter==OVERSAMPLE-1, sample the line: shift register <= {line, shift[7:1]} (LSB first), counter=0, bit index+1. Sampling bit 7 -> STOP.
  - STOP: on the pulse where counter==OVERSAMPLE-1, sample the line.
    - line==STOP_BIT -> deliver byte, go to IDLE.
    - otherwise -> FRAME_ERR_OUT=1 for the next cycle, byte discarded, go to WAIT_IDLE.
  - WAIT_IDLE (break or line held low): stay until a pulse with line==LINE_IDLE, then IDLE. This stops a stuck-low line producing repeated framing errors.
  - Any unused state encoding -> IDLE.
- Delivery (registered; VLD_OUT/DATA_OUT update on the edge after the stop-sample edge):
  - VLD_OUT=0: load DATA_OUT, set VLD_OUT=1.
  - VLD_OUT=1 and RDY_IN=1 in the same cycle: load the new byte, VLD_OUT stays 1, no overrun.
  - VLD_OUT=1 and RDY_IN=0: keep the old byte, drop the new one, OVERRUN_OUT=1 for one cycle.
  - Otherwise VLD_OUT clears on a transfer (VLD_OUT && RDY_IN).
- DATA_OUT is stable while VLD_OUT=1 and no transfer occurs.
- Latency:
  - RX_IN change visible at line after SYNC_STAGES edges.
  - VLD_OUT rises 1 cycle after the mid-stop-bit sample, i.e. about 9.5 bit periods after the start edge.
- A new start bit is accepted from IDLE immediately after a good stop sample, so back-to-back frames from spio_uart_tx (stop bit followed directly by a start bit) are received without loss.

Decomposition:
- spio_uart_common.h (existing shared header): LINE_IDLE, START_BIT, STOP_BIT. Add the receiver state encodings here so testbenches can reuse them.
- Sub-module spio_uart_sync: parameterised SYNC_STAGES flip-flop synchroniser with reset value LINE_IDLE; reusable for the CTS/RTS lines.

Test Plan:
- Single frame 0xA5, OVERSAMPLE=16, RDY_IN=1 -> one VLD_OUT cycle with DATA_OUT=0xA5; FRAME_ERR_OUT and OVERRUN_OUT stay 0.
- RX_IN low for 3 sample pulses, then high -> no VLD_OUT, state returns to IDLE, a following frame 0x5A is received correctly.
- Frame 0x3C with stop bit driven 0, line held low for 3 bit periods, then frame 0x81 -> one FRAME_ERR_OUT pulse, no VLD for 0x3C, no further errors while low, then DATA_OUT=0x81.
- Frames 0x00 then 0xFF back-to-back with RDY_IN=0 -> DATA_OUT=0x00, OVERRUN_OUT pulses once. Raise RDY_IN -> 0x00 transferred, VLD_OUT=0.
- RESET_IN asserted for one cycle after bit 3 of 0x77, then frame 0x12 -> no output for 0x77, DATA_OUT=0x12 delivered.
- Loopback from spio_uart_tx to this block with a shared baud generator (1x and 16x pulses), random 256-byte stream -> all bytes received in order, no errors.
